// File: rtl/alu_if.sv
// ALU operand/result bundle. The datapath side (master) drives the operands
// and opcode. The ALU side (slave) returns the combinational result and the
// registered status flags.
interface alu_if #(
    parameter int n = 32
);
    logic [n-1:0] R2;
    logic [n-1:0] R3;
    logic [2:0]   ALUOp;
    logic [n-1:0] R0;
    logic         Overflow;
    logic         Zero;
    logic         Carry;

    modport master (
        output R2, R3, ALUOp,
        input  R0, Overflow, Zero, Carry
    );

    modport slave (
        input  R2, R3, ALUOp,
        output R0, Overflow, Zero, Carry
    );
endinterface

// File: rtl/alu.sv
// n-bit integer ALU with eight operations. R0 is purely combinational.
// Overflow/Zero/Carry are captured in a status register that is cleared
// asynchronously. ADD, SUB and SLT share one adder: subtraction is
// performed as R2 + ~R3 + 1.
module alu #(
    parameter int n = 32
) (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);
    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_NOT  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic         sub_op;
    logic [n-1:0] b_eff;
    logic [n:0]   sum;
    logic         v_raw;
    logic         lt;
    logic [n-1:0] r0;
    logic         overflow_d, zero_d, carry_d;
    logic         overflow_q, zero_q, carry_q;

    // Shared adder: the operand B is inverted and a carry-in is injected for SUB/SLT.
    always_comb begin
        sub_op = (bus.ALUOp == OP_SUB) || (bus.ALUOp == OP_SLT);
        b_eff  = sub_op ? ~bus.R3 : bus.R3;
        sum    = {1'b0, bus.R2} + {1'b0, b_eff} + {{n{1'b0}}, sub_op};
        // Signed overflow of the actual addition performed. This covers both ADD
        // and SUB, because ~R3 carries the inverted sign of R3.
        v_raw  = (bus.R2[n-1] == b_eff[n-1]) && (sum[n-1] != bus.R2[n-1]);
        // Signed less-than stays correct even when R2 - R3 overflows.
        lt     = sum[n-1] ^ v_raw;
    end

    // Result multiplexer; every opcode is decoded.
    always_comb begin
        r0 = '0;
        case (bus.ALUOp)
            OP_MOV:  r0 = bus.R2;
            OP_NOT:  r0 = ~bus.R2;
            OP_ADD:  r0 = sum[n-1:0];
            OP_NOR:  r0 = ~(bus.R2 | bus.R3);
            OP_SUB:  r0 = sum[n-1:0];
            OP_NAND: r0 = ~(bus.R2 & bus.R3);
            OP_AND:  r0 = bus.R2 & bus.R3;
            OP_SLT:  r0 = {{(n-1){1'b0}}, lt};
            default: r0 = '0;
        endcase
    end

    // Next-state status flags. Carry and Overflow are only meaningful for ADD/SUB.
    always_comb begin
        zero_d     = (r0 == '0);
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        if (bus.ALUOp == OP_ADD || bus.ALUOp == OP_SUB) begin
            carry_d    = sum[n];
            overflow_d = v_raw;
        end
    end

    // Status register, cleared immediately by reset, captured on every rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
        end
    end

    assign bus.R0       = r0;
    assign bus.Overflow = overflow_q;
    assign bus.Zero     = zero_q;
    assign bus.Carry    = carry_q;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (n = 32). A behavioural model built from plain
// integer arithmetic predicts R0 and the flags. A compare process checks the
// DUT against the model on every falling edge. Directed vectors with
// hand-computed literals pin the model down.
module tb_alu;
    localparam int N = 32;

    localparam logic [2:0] MOV  = 3'b000;
    localparam logic [2:0] NOT_ = 3'b001;
    localparam logic [2:0] ADD  = 3'b010;
    localparam logic [2:0] NOR_ = 3'b011;
    localparam logic [2:0] SUB  = 3'b100;
    localparam logic [2:0] NAND_= 3'b101;
    localparam logic [2:0] AND_ = 3'b110;
    localparam logic [2:0] SLT  = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    alu_if #(.n(N)) bus ();
    alu #(.n(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    // Reference model: signed/unsigned integer arithmetic on 64-bit values.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v, output logic z, output logic c);
        longint sa, sb, ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r = 32'h0; v = 1'b0; c = 1'b0;
        case (op)
            MOV:   r = a;
            NOT_:  r = ~a;
            ADD: begin
                res = ua + ub;
                r = res[31:0];
                c = (res >= 64'sd4294967296);
                v = ((sa + sb) > 64'sd2147483647) || ((sa + sb) < -64'sd2147483648);
            end
            NOR_:  r = ~(a | b);
            SUB: begin
                res = ua - ub;
                r = res[31:0];
                c = (ua >= ub);
                v = ((sa - sb) > 64'sd2147483647) || ((sa - sb) < -64'sd2147483648);
            end
            NAND_: r = ~(a & b);
            AND_:  r = a & b;
            default: r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        z = (r == 32'h0);
    endfunction

    // Expected status register: cleared by reset, loaded from the model at each rising edge.
    logic ev, ez, ec;
    always @(posedge clk or negedge rst_n) begin
        logic [31:0] rr;
        logic mv, mz, mc;
        if (!rst_n) begin
            ev <= 1'b0; ez <= 1'b0; ec <= 1'b0;
        end else begin
            model(bus.ALUOp, bus.R2, bus.R3, rr, mv, mz, mc);
            ev <= mv; ez <= mz; ec <= mc;
        end
    end

    // Compare process: each falling edge, R0 against the model and flags against the expected register.
    always @(negedge clk) begin
        logic [31:0] er;
        logic mv, mz, mc;
        if (chk_en) begin
            model(bus.ALUOp, bus.R2, bus.R3, er, mv, mz, mc);
            tests++;
            if (bus.R0 !== er) begin
                fails++;
                $display("FAIL model_r0 op=%b a=%h b=%h got=%h exp=%h", bus.ALUOp, bus.R2, bus.R3, bus.R0, er);
            end
            tests++;
            if ({bus.Overflow, bus.Zero, bus.Carry} !== {ev, ez, ec}) begin
                fails++;
                $display("FAIL model_flags op=%b got VZC=%b%b%b exp=%b%b%b", bus.ALUOp,
                         bus.Overflow, bus.Zero, bus.Carry, ev, ez, ec);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Directed vector with literal expectations: R0 right away, flags after the next edge.
    task automatic dir(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic [2:0] exp_vzc);
        @(posedge clk);
        #2;
        bus.ALUOp = op; bus.R2 = a; bus.R3 = b;
        #1;
        check({name, "_r0"}, bus.R0, exp_r);
        @(posedge clk);
        #1;
        check({name, "_vzc"}, {29'b0, bus.Overflow, bus.Zero, bus.Carry}, {29'b0, exp_vzc});
        $display("[TB] %s op=%b a=%h b=%h R0=%h VZC=%b%b%b", name, op, a, b, bus.R0,
                 bus.Overflow, bus.Zero, bus.Carry);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.ALUOp = MOV; bus.R2 = 32'h1234_5678; bus.R3 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {29'b0, bus.Overflow, bus.Zero, bus.Carry}, 32'h0);
        check("reset_r0_tracks", bus.R0, 32'h1234_5678);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Directed vectors; exp_vzc is {Overflow, Zero, Carry}.
        dir("mov",        MOV,  32'd421,      32'h0,        32'h0000_01A5, 3'b000);
        dir("not_aa",     NOT_, 32'hAAAA_AAAA, 32'h0,       32'h5555_5555, 3'b000);
        dir("not_ff",     NOT_, 32'hFFFF_FFFF, 32'h0,       32'h0000_0000, 3'b010);
        dir("add_ff_ff",  ADD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'b001);
        dir("add_ovf",    ADD,  32'h7FFF_FFFF, 32'h1,       32'h8000_0000, 3'b100);
        dir("sub_54",     SUB,  32'd54,       32'hFFFF_FFCB, 32'h0000_006B, 3'b000);
        dir("sub_1000",   SUB,  32'd1000,     32'd999,      32'h0000_0001, 3'b001);
        dir("sub_ff_ff",  SUB,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 3'b011);
        dir("sub_5_12",   SUB,  32'd5,        32'd12,       32'hFFFF_FFF9, 3'b000);
        dir("sub_ovf",    SUB,  32'h8000_0000, 32'h1,       32'h7FFF_FFFF, 3'b101);
        dir("nor",        NOR_, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 3'b010);
        dir("nand",       NAND_,32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 3'b000);
        dir("and",        AND_, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 3'b010);
        dir("nand_ff",    NAND_,32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 3'b010);
        dir("slt_m1_5",   SLT,  32'hFFFF_FFFF, 32'd5,       32'h0000_0001, 3'b000);
        dir("slt_5_m1",   SLT,  32'd5,        32'hFFFF_FFFF, 32'h0000_0000, 3'b010);
        dir("slt_m2_m1",  SLT,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 3'b000);
        dir("slt_25_25",  SLT,  32'd25,       32'd25,       32'h0000_0000, 3'b010);
        dir("slt_ovf",    SLT,  32'h7FFF_FFFF, 32'h8000_0001, 32'h0000_0000, 3'b010);
        dir("slt_neg_0",  SLT,  32'hF000_0001, 32'h0,       32'h0000_0001, 3'b000);

        // Asynchronous reset pulse between edges, with Overflow set beforehand.
        dir("pre_rst",    ADD,  32'h7FFF_FFFF, 32'h1,       32'h8000_0000, 3'b100);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_flags", {29'b0, bus.Overflow, bus.Zero, bus.Carry}, 32'h0);
        check("rst_r0_hold", bus.R0, 32'h8000_0000);
        bus.R2 = 32'hFFFF_FFFF;
        #1;
        check("rst_r0_tracks", bus.R0, 32'h0000_0000);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_release_noedge", {29'b0, bus.Overflow, bus.Zero, bus.Carry}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_first_capture", {29'b0, bus.Overflow, bus.Zero, bus.Carry}, 32'h3);
        $display("[TB] reset pulse: flags after release VZC=%b%b%b", bus.Overflow, bus.Zero, bus.Carry);

        // Randomised traffic; the compare process checks every cycle.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            bus.ALUOp = 3'($urandom_range(0, 7));
            bus.R2 = pick();
            bus.R3 = pick();
        end
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
